// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serialising RAM request responder.
// State, mask, owner and IO-region codes used by mem_ctrl and mem_arbiter.
package mem_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_BYTE = 2'b01;
  localparam logic [1:0] MASK_HALF = 2'b10;
  localparam logic [1:0] MASK_WORD = 2'b11;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam logic [1:0] IO_SEL = 2'b11;

  function automatic logic [2:0] mask_bytes(input logic [1:0] mask);
    case (mask)
      MASK_BYTE: mask_bytes = 3'd1;
      MASK_HALF: mask_bytes = 3'd2;
      MASK_WORD: mask_bytes = 3'd4;
      default:   mask_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Combinational priority select among pending requests: MEM write > MEM read > IF read.
// Emits the winner's owner, direction, base address, store data and byte count.
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = 17,
  parameter int IO_HI  = 17
) (
  input  logic              mem_r_enable_i,
  input  logic              mem_w_enable_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_w_data_i,
  input  logic [1:0]        mem_mask_i,
  input  logic              if_r_enable_i,
  input  logic [31:0]       if_addr_i,
  output logic              req_vld,
  output logic              req_owner,
  output logic              req_rw,
  output logic              req_io,
  output logic [RAM_AW-1:0] req_base,
  output logic [31:0]       req_data,
  output logic [2:0]        req_cnt
);

  logic mem_io;
  logic unused_addr;

  assign mem_io      = (mem_addr_i[IO_HI -: 2] == IO_SEL);
  assign unused_addr = ^{mem_addr_i[31:RAM_AW], if_addr_i[31:RAM_AW]};

  always_comb begin
    req_vld   = 1'b0;
    req_owner = OWN_IF;
    req_rw    = 1'b0;
    req_io    = 1'b0;
    req_base  = if_addr_i[RAM_AW-1:0];
    req_data  = mem_w_data_i;
    req_cnt   = 3'd4;
    if (mem_w_enable_i) begin
      req_vld   = 1'b1;
      req_owner = OWN_MEM;
      req_rw    = 1'b1;
      req_base  = mem_addr_i[RAM_AW-1:0];
      req_cnt   = mask_bytes(mem_mask_i);
    end else if (mem_r_enable_i) begin
      req_vld   = 1'b1;
      req_owner = OWN_MEM;
      req_io    = mem_io;
      req_base  = mem_addr_i[RAM_AW-1:0];
      req_cnt   = mem_io ? 3'd1 : 3'd4;
    end else if (if_r_enable_i) begin
      req_vld   = 1'b1;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Responder for CPU MEM/IF requests: serialises word/half/byte accesses onto a
// byte-wide synchronous RAM/IO bus and reassembles read words with a done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = 17,
  parameter int IO_HI  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_enable_i,
  input  logic              mem_w_enable_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_w_data_i,
  input  logic [1:0]        mem_mask_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_r_data_o,
  input  logic              if_r_enable_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_r_data_o,
  output logic              busy_o,
  output logic [RAM_AW-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  input  logic [7:0]        mem_din_i
);

  logic              req_vld, req_owner, req_rw, req_io;
  logic [RAM_AW-1:0] req_base;
  logic [31:0]       req_data;
  logic [2:0]        req_cnt;

  logic [1:0]        state;
  logic [2:0]        idx, cnt_q;
  logic [RAM_AW-1:0] base_q;
  logic [31:0]       data_q, asm_q, mem_rd_q, if_rd_q;
  logic              rw_q, own_q, io_q;
  logic              cap_vld_p1;
  logic [1:0]        cap_lane_p1;
  logic [2:0]        lane_now;

  mem_arbiter #(.RAM_AW(RAM_AW), .IO_HI(IO_HI)) u_arb (
    .mem_r_enable_i (mem_r_enable_i),
    .mem_w_enable_i (mem_w_enable_i),
    .mem_addr_i     (mem_addr_i),
    .mem_w_data_i   (mem_w_data_i),
    .mem_mask_i     (mem_mask_i),
    .if_r_enable_i  (if_r_enable_i),
    .if_addr_i      (if_addr_i),
    .req_vld        (req_vld),
    .req_owner      (req_owner),
    .req_rw         (req_rw),
    .req_io         (req_io),
    .req_base       (req_base),
    .req_data       (req_data),
    .req_cnt        (req_cnt)
  );

  // idx already points at the next byte, so the address on the bus is lane idx-1
  assign lane_now = idx - 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= 3'd0;
      cnt_q       <= 3'd0;
      base_q      <= '0;
      data_q      <= '0;
      rw_q        <= 1'b0;
      own_q       <= OWN_IF;
      io_q        <= 1'b0;
      asm_q       <= '0;
      mem_rd_q    <= '0;
      if_rd_q     <= '0;
      cap_vld_p1  <= 1'b0;
      cap_lane_p1 <= 2'd0;
      mem_a_o     <= '0;
      mem_dout_o  <= '0;
      mem_wr_o    <= 1'b0;
    end else begin
      // Capture stage: read byte arrives one cycle after its address
      cap_vld_p1  <= (state == S_XFER) && !rw_q;
      cap_lane_p1 <= lane_now[1:0];
      if (cap_vld_p1) begin
        if (io_q) asm_q <= {4{mem_din_i}};
        else      asm_q[{cap_lane_p1, 3'b000} +: 8] <= mem_din_i;
      end

      case (state)
        S_IDLE: begin
          if (req_vld) begin
            own_q  <= req_owner;
            rw_q   <= req_rw;
            io_q   <= req_io;
            base_q <= req_base;
            data_q <= req_data;
            cnt_q  <= req_cnt;
            if (req_cnt == 3'd0) begin
              state <= S_DONE;
            end else begin
              state      <= S_XFER;
              mem_a_o    <= req_base;
              mem_dout_o <= req_data[7:0];
              mem_wr_o   <= req_rw;
              idx        <= 3'd1;
            end
          end
        end
        S_XFER: begin
          if (idx == cnt_q) begin
            mem_wr_o <= 1'b0;
            state    <= rw_q ? S_DONE : S_WAIT;
          end else begin
            mem_a_o    <= base_q + RAM_AW'(idx);
            mem_dout_o <= data_q[{idx[1:0], 3'b000} +: 8];
            idx        <= idx + 3'd1;
          end
        end
        S_WAIT: state <= S_DONE;
        default: begin
          state <= S_IDLE;
          if (!rw_q) begin
            if (own_q == OWN_MEM) mem_rd_q <= asm_q;
            else                  if_rd_q  <= asm_q;
          end
        end
      endcase
    end
  end

  assign busy_o       = (state != S_IDLE);
  assign mem_done_o   = (state == S_DONE) && (own_q == OWN_MEM);
  assign if_done_o    = (state == S_DONE) && (own_q == OWN_IF);
  assign mem_r_data_o = (mem_done_o && !rw_q) ? asm_q : mem_rd_q;
  assign if_r_data_o  = if_done_o ? asm_q : if_rd_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the CPU's RAM request interface. Serves the MEM stage (loads and stores) and the IF stage (instruction word reads).
- Translates each word, half or byte request into a sequence of single-byte accesses on the byte-wide external synchronous RAM/IO bus.
- Returns assembled read data with a one-cycle done pulse. Sits between the core pipeline and the top-level memory pins.

Parameters:
- RAM_AW, 17, external byte-address width; mem_a_o = (base + byte index)[RAM_AW-1:0].
- IO_HI, 17, MSB of the 2-bit IO-region selector; a request is IO when addr[IO_HI:IO_HI-1] == 2'b11.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset rst, synchronous, active-high
- mem_r_enable_i  in  1  MEM load request, level, held until accepted
- mem_w_enable_i  in  1  MEM store request, level, held until accepted
- mem_addr_i  in  32  MEM byte address; loads arrive word-aligned
- mem_w_data_i  in  32  store data; byte k is [8k+7:8k]
- mem_mask_i  in  2  store size: 01 byte, 10 half, 11 word, 00 none
- mem_done_o  out  1  one-cycle pulse: MEM request complete
- mem_r_data_o  out  32  load word, valid while mem_done_o=1
- if_r_enable_i  in  1  IF word-read request, level
- if_addr_i  in  32  IF word-aligned address
- if_done_o  out  1  one-cycle pulse: IF read complete
- if_r_data_o  out  32  instruction word, valid while if_done_o=1
- busy_o  out  1  shared by both clients; high whenever state != IDLE
- mem_a_o  out  RAM_AW  external byte address (registered)
- mem_dout_o  out  8  external write byte (registered)
- mem_wr_o  out  1  external write strobe (registered)
- mem_din_i  in  8  external read byte; valid the cycle after its address

Behaviour:
- Reset values: all outputs 0. State = IDLE, byte index = 0, read-assembly register = 0.
- Reset mid-operation: sequence aborted, no done pulse. mem_wr_o is 0 from the cycle after rst.

States:
- IDLE → XFER on acceptance.
- XFER → WAIT (reads) or DONE (writes) after the last byte address is issued.
- WAIT → DONE.
- DONE → IDLE.

Acceptance:
- Requests are accepted only in IDLE (cycle T); the request is latched in T.
- Requests seen in XFER/WAIT/DONE are ignored; clients hold enable high until accepted.

Arbitration and sizes:
- When several requests are present: MEM write > MEM read > IF read.
- If MEM r and w are both high, the write is performed and the read is ignored.
- Byte count n: MEM read = 4, or 1 if IO region. IF read = 4. Write = 1 / 2 / 4 for mask 01 / 10 / 11.
- Write with mask 00: no external access; DONE in cycle T+1.

XFER (cycles T+1 .. T+n):
- mem_a_o = base + k for k = 0..n-1. No carry beyond RAM_AW; the address wraps.
- Writes: mem_wr_o = 1 and mem_dout_o = byte k of the latched data.
- Reads: mem_wr_o = 0; mem_din_i is captured in cycle T+k+2 into byte lane k.
- IO read: the single byte is replicated into all four lanes.

Done timing:
- Reads: DONE in cycle T+n+2, so word read → T+6 and IO read → T+3.
- Writes: DONE in cycle T+n+1, so SW → T+5, SH → T+3, SB → T+2.

DONE cycle:
- Exactly one of mem_done_o / if_done_o is 1, selected by the latched owner.
- Read data is valid on that client's r_data output. busy_o stays 1.
- r_data outputs hold their last value otherwise.

busy_o: 1 from T+1 through DONE, 0 in IDLE. mem_wr_o is 0 outside XFER.

Decomposition:
- Shared package (defines header):
  - state encodings IDLE/XFER/WAIT/DONE
  - mask codes MASK_NONE/BYTE/HALF/WORD (2'b00/01/10/11)
  - owner codes OWN_IF/OWN_MEM
  - IO selector value 2'b11
- Sub-module mem_arbiter: combinational priority select of the winning request in IDLE. Outputs: owner, rw, base address, data, byte count.
- Sequencing FSM and assembly register stay in mem_ctrl.

Test Plan:
- LW at 0x00000104, RAM bytes 0x11,0x22,0x33,0x44 at 0x104..0x107 → addresses 0x104..0x107 in T+1..T+4; mem_done_o only in T+6 with mem_r_data_o = 0x44332211.
- SB mask 01, mem_w_data_i = 0xA5A5A5A5, addr 0x00000203 → one write (0x203, 0xA5) in T+1; mem_done_o at T+2; busy_o = 1 in T+1..T+2.
- SW 0xDEADBEEF at 0x10 → writes EF, BE, AD, DE at 0x10..0x13 in T+1..T+4; done at T+5.
- IO read addr 0x00030000, device returns 0x7F → one read; done at T+3 with mem_r_data_o = 0x7F7F7F7F.
- MEM load and IF read asserted together at T → MEM served first with mem_done_o at T+6, if_done_o stays 0. IF accepted in the following IDLE cycle; its done arrives 6 cycles after that acceptance.
- rst asserted in T+2 of an SW → no done pulse; mem_wr_o = 0 from T+3; all outputs 0.
- New request then completes normally.
